// File: rtl/csr_trap_unit_if.sv
// Core-side view of csr_trap_unit: CSR access port plus trap inputs and PC redirect outputs.
interface csr_trap_unit_if #(
  parameter int NUM_IRQ = 4
);
  logic [11:0]        csr_addr;
  logic [1:0]         csr_op;
  logic [31:0]        csr_wdata;
  logic [31:0]        csr_rdata;
  logic               csr_illegal;
  logic [31:0]        pc;
  logic               exc_valid;
  logic [4:0]         exc_cause;
  logic [NUM_IRQ-1:0] irq;
  logic               is_mret;
  logic [31:0]        epc;
  logic               epc_taken;

  modport master (
    output csr_addr, csr_op, csr_wdata, pc, exc_valid, exc_cause, irq, is_mret,
    input  csr_rdata, csr_illegal, epc, epc_taken
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata, pc, exc_valid, exc_cause, irq, is_mret,
    output csr_rdata, csr_illegal, epc, epc_taken
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt latching, trap entry / MRET sequencing and a
// registered PC redirect.
module csr_trap_unit #(
  parameter int NUM_IRQ  = 4,
  parameter int IRQ_LSB  = 16,
  parameter int SYNC_IRQ = 1,
  parameter int CYCLE_EN = 1
) (
  input logic            clk,
  input logic            rst,
  csr_trap_unit_if.slave bus
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [NUM_IRQ-1:0] mip_q, mip_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mepc_q, mepc_d;
  logic               mcause_int_q, mcause_int_d;
  logic [4:0]         mcause_code_q, mcause_code_d;
  logic [63:0]        mcycle_q, mcycle_d;
  logic [31:0]        epc_q, epc_d;
  logic               epc_taken_q, epc_taken_d;

  // Interrupt inputs are asynchronous to clk unless the integrator says otherwise.
  generate
    if (SYNC_IRQ != 0) begin : g_sync
      logic [NUM_IRQ-1:0] sync_q, sync_d;
      always_comb begin
        sync_d = bus.irq;
        mip_d  = sync_q;
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync_d;
      end
    end else begin : g_nosync
      always_comb mip_d = bus.irq;
    end
  endgenerate

  logic [31:0] mip_word, mie_word;
  always_comb begin
    mip_word = '0;
    mie_word = '0;
    mip_word[IRQ_LSB +: NUM_IRQ] = mip_q;
    mie_word[IRQ_LSB +: NUM_IRQ] = mie_q;
  end

  logic        csr_legal;
  logic [31:0] csr_old;
  always_comb begin
    csr_legal = 1'b1;
    csr_old   = '0;
    case (bus.csr_addr)
      A_MSTATUS: csr_old = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      A_MIE:     csr_old = mie_word;
      A_MTVEC:   csr_old = mtvec_q;
      A_MEPC:    csr_old = mepc_q;
      A_MCAUSE:  csr_old = {mcause_int_q, 26'b0, mcause_code_q};
      A_MIP:     csr_old = mip_word;
      A_MCYCLE:  if (CYCLE_EN != 0) csr_old = mcycle_q[31:0];  else csr_legal = 1'b0;
      A_MCYCLEH: if (CYCLE_EN != 0) csr_old = mcycle_q[63:32]; else csr_legal = 1'b0;
      default:   csr_legal = 1'b0;
    endcase
  end

  assign bus.csr_rdata   = (bus.csr_op != OP_NONE && csr_legal) ? csr_old : '0;
  assign bus.csr_illegal = (bus.csr_op != OP_NONE) && !csr_legal;

  logic [31:0] csr_new;
  always_comb begin
    case (bus.csr_op)
      OP_RW:   csr_new = bus.csr_wdata;
      OP_RS:   csr_new = csr_old | bus.csr_wdata;
      default: csr_new = csr_old & ~bus.csr_wdata;
    endcase
  end

  // Lowest-numbered pending and enabled line wins.
  logic [NUM_IRQ-1:0] pend;
  logic               int_pend;
  logic [4:0]         int_code;
  assign pend     = mip_q & mie_q;
  assign int_pend = mstatus_mie_q & (|pend);
  always_comb begin
    int_code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) int_code = 5'(IRQ_LSB + i);
  end

  logic       trap_int;
  logic [4:0] trap_code;
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_int_d   = mcause_int_q;
    mcause_code_d  = mcause_code_q;
    mcycle_d       = mcycle_q + 64'd1;
    epc_d          = epc_q;
    epc_taken_d    = 1'b0;
    trap_int       = !bus.exc_valid;
    trap_code      = bus.exc_valid ? bus.exc_cause : int_code;
    if (bus.exc_valid || int_pend) begin
      mepc_d         = bus.pc & ~32'h3;
      mcause_int_d   = trap_int;
      mcause_code_d  = trap_code;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      epc_d          = {mtvec_q[31:2], 2'b00};
      if (trap_int && mtvec_q[0]) epc_d = epc_d + {25'b0, trap_code, 2'b00};
      epc_taken_d    = 1'b1;
    end else if (bus.is_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      epc_d          = mepc_q;
      epc_taken_d    = 1'b1;
    end else if (bus.csr_op != OP_NONE && csr_legal) begin
      // A counter write replaces the half and suppresses that cycle's increment.
      case (bus.csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = csr_new[3];
          mstatus_mpie_d = csr_new[7];
        end
        A_MIE:     mie_d    = csr_new[IRQ_LSB +: NUM_IRQ];
        A_MTVEC:   mtvec_d  = {csr_new[31:2], 1'b0, csr_new[0]};
        A_MEPC:    mepc_d   = {csr_new[31:2], 2'b00};
        A_MCAUSE: begin
          mcause_int_d  = csr_new[31];
          mcause_code_d = csr_new[4:0];
        end
        A_MCYCLE:  mcycle_d = {mcycle_q[63:32], csr_new};
        A_MCYCLEH: mcycle_d = {csr_new, mcycle_q[31:0]};
        default: ;
      endcase
    end
    if (CYCLE_EN == 0) mcycle_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_int_q   <= 1'b0;
      mcause_code_q  <= '0;
      mcycle_q       <= '0;
      epc_q          <= '0;
      epc_taken_q    <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_int_q   <= mcause_int_d;
      mcause_code_q  <= mcause_code_d;
      mcycle_q       <= mcycle_d;
      epc_q          <= epc_d;
      epc_taken_q    <= epc_taken_d;
    end
  end

  assign bus.epc       = epc_q;
  assign bus.epc_taken = epc_taken_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed and randomized checks of csr_trap_unit against an architectural CSR/trap model.
module tb_csr_trap_unit;
  localparam int NUM_IRQ = 4;
  localparam int IRQ_LSB = 16;
  localparam logic [31:0] IRQ_MASK = 32'h000F_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #50 clk = ~clk;

  csr_trap_unit_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  csr_trap_unit #(.NUM_IRQ(NUM_IRQ), .IRQ_LSB(IRQ_LSB), .SYNC_IRQ(1), .CYCLE_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model: CSRs held as full 32-bit words as software sees them.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_epc;
  logic [63:0] m_mcycle;
  logic        m_taken;
  logic [3:0]  m_ih1, m_ih2;

  task automatic m_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_epc = 0;
    m_mcycle = 0; m_taken = 0; m_ih1 = 0; m_ih2 = 0;
  endtask

  function automatic logic [32:0] m_read(input logic [11:0] a);
    logic [31:0] mipw;
    mipw = 32'(m_ih2) << IRQ_LSB;
    case (a)
      12'h300: return {1'b1, m_mstatus};
      12'h304: return {1'b1, m_mie};
      12'h305: return {1'b1, m_mtvec};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h344: return {1'b1, mipw};
      12'hB00: return {1'b1, m_mcycle[31:0]};
      12'hB80: return {1'b1, m_mcycle[63:32]};
      default: return 33'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven, then cross the edge.
  task automatic tick();
    logic [31:0] pend, oldv, newv, n_mstatus, n_mie, n_mtvec, n_mepc, n_mcause, n_epc;
    logic [63:0] n_mcycle;
    logic [32:0] rd;
    logic        n_taken, is_int;
    logic [4:0]  code;
    pend = (32'(m_ih2) << IRQ_LSB) & m_mie;
    n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mepc = m_mepc;
    n_mcause = m_mcause; n_epc = m_epc; n_taken = 0; n_mcycle = m_mcycle + 64'd1;
    if (bus.exc_valid || (m_mstatus[3] && pend != 0)) begin
      is_int = !bus.exc_valid;
      code = bus.exc_cause;
      if (is_int) for (int b = 31; b >= 0; b--) if (pend[b]) code = 5'(b);
      n_mepc = bus.pc & ~32'h3;
      n_mcause = {is_int, 26'b0, code};
      n_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      n_epc = (m_mtvec & ~32'h3) + ((is_int && m_mtvec[0]) ? 32'(code) * 32'd4 : 32'd0);
      n_taken = 1;
    end else if (bus.is_mret) begin
      n_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      n_epc = m_mepc;
      n_taken = 1;
    end else if (bus.csr_op != 2'b00) begin
      rd = m_read(bus.csr_addr);
      if (rd[32]) begin
        oldv = rd[31:0];
        if (bus.csr_op == 2'b01)      newv = bus.csr_wdata;
        else if (bus.csr_op == 2'b10) newv = oldv | bus.csr_wdata;
        else                          newv = oldv & ~bus.csr_wdata;
        case (bus.csr_addr)
          12'h300: n_mstatus = newv & 32'h88;
          12'h304: n_mie = newv & IRQ_MASK;
          12'h305: n_mtvec = newv & ~32'h2;
          12'h341: n_mepc = newv & ~32'h3;
          12'h342: n_mcause = newv & 32'h8000_001F;
          12'hB00: n_mcycle = {m_mcycle[63:32], newv};
          12'hB80: n_mcycle = {newv, m_mcycle[31:0]};
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mepc = n_mepc;
    m_mcause = n_mcause; m_epc = n_epc; m_taken = n_taken; m_mcycle = n_mcycle;
    m_ih2 = m_ih1; m_ih1 = bus.irq;
  endtask

  task automatic idle();
    bus.csr_op = 2'b00; bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0;
    bus.exc_valid = 1'b0; bus.exc_cause = 5'h0; bus.is_mret = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
  endtask

  // Present a side-effect-free read (set with zero mask) and let it settle.
  task automatic rd_setup(input logic [11:0] a);
    bus.csr_op = 2'b10; bus.csr_addr = a; bus.csr_wdata = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    idle(); bus.irq = 0; bus.pc = 0;
    #10;
    rd_setup(12'h305);
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL reset_hold_mtvec got=%h exp=%h", bus.csr_rdata, 32'h0); end
    n_cmp++; if (bus.epc_taken !== 1'b0) begin n_err++; $display("FAIL reset_hold_taken got=%b exp=0", bus.epc_taken); end
    idle();
    @(posedge clk); #1;
    rst = 1'b1; m_reset();
    cmd(2'b01, 12'h305, 32'h0000_0123); tick();
    idle(); tick(); tick();
    rd_setup(12'h305);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0121) begin n_err++; $display("FAIL reset_pre_mtvec got=%h exp=%h", bus.csr_rdata, 32'h0000_0121); end
    rd_setup(12'hB00);
    n_cmp++; if (bus.csr_rdata !== 32'd3) begin n_err++; $display("FAIL reset_pre_mcycle got=%h exp=%h", bus.csr_rdata, 32'd3); end
    #20;
    rst = 1'b0; m_reset();
    #1;
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL reset_mid_mcycle got=%h exp=%h", bus.csr_rdata, 32'h0); end
    rd_setup(12'h305);
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL reset_mid_mtvec got=%h exp=%h", bus.csr_rdata, 32'h0); end
    n_cmp++; if (bus.epc !== 32'h0) begin n_err++; $display("FAIL reset_mid_epc got=%h exp=%h", bus.epc, 32'h0); end
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_vectored_irq();
    logic [31:0] exp_taken [3] = '{32'd0, 32'd0, 32'd1};
    cmd(2'b01, 12'h305, 32'h1000_0001); tick();
    cmd(2'b01, 12'h304, 32'h0002_0000); tick();
    cmd(2'b10, 12'h300, 32'h0000_0008); tick();
    idle(); bus.pc = 32'h0000_1238; bus.irq = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (32'(bus.epc_taken) !== exp_taken[k]) begin n_err++; $display("FAIL irq_taken_c%0d got=%b exp=%0d", k, bus.epc_taken, exp_taken[k]); end
    end
    n_cmp++; if (bus.epc !== 32'h1000_0044) begin n_err++; $display("FAIL irq_epc got=%h exp=%h", bus.epc, 32'h1000_0044); end
    rd_setup(12'h341);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_1238) begin n_err++; $display("FAIL irq_mepc got=%h exp=%h", bus.csr_rdata, 32'h0000_1238); end
    rd_setup(12'h342);
    n_cmp++; if (bus.csr_rdata !== 32'h8000_0011) begin n_err++; $display("FAIL irq_mcause got=%h exp=%h", bus.csr_rdata, 32'h8000_0011); end
    rd_setup(12'h300);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0080) begin n_err++; $display("FAIL irq_mstatus got=%h exp=%h", bus.csr_rdata, 32'h0000_0080); end
    idle(); tick();
    n_cmp++; if (bus.epc_taken !== 1'b0) begin n_err++; $display("FAIL irq_strobe_len got=%b exp=0", bus.epc_taken); end
    n_cmp++; if (bus.epc !== 32'h1000_0044) begin n_err++; $display("FAIL irq_epc_hold got=%h exp=%h", bus.epc, 32'h1000_0044); end
  endtask

  task automatic test_priority();
    bus.irq = 4'b0000; idle(); tick(); tick(); tick();
    cmd(2'b01, 12'h304, 32'h0007_0000); tick();
    cmd(2'b10, 12'h300, 32'h0000_0008); tick();
    idle(); bus.irq = 4'b0101; tick(); tick(); tick();
    n_cmp++; if (bus.epc_taken !== 1'b1) begin n_err++; $display("FAIL lowest_taken got=%b exp=1", bus.epc_taken); end
    n_cmp++; if (bus.epc !== 32'h1000_0040) begin n_err++; $display("FAIL lowest_epc got=%h exp=%h", bus.epc, 32'h1000_0040); end
    rd_setup(12'h342);
    n_cmp++; if (bus.csr_rdata !== 32'h8000_0010) begin n_err++; $display("FAIL lowest_mcause got=%h exp=%h", bus.csr_rdata, 32'h8000_0010); end
    cmd(2'b10, 12'h300, 32'h0000_0008); tick();
    idle(); bus.exc_valid = 1'b1; bus.exc_cause = 5'd2; bus.pc = 32'h0000_2000; tick();
    idle();
    n_cmp++; if (bus.epc !== 32'h1000_0000) begin n_err++; $display("FAIL exc_wins_epc got=%h exp=%h", bus.epc, 32'h1000_0000); end
    rd_setup(12'h342);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0002) begin n_err++; $display("FAIL exc_wins_mcause got=%h exp=%h", bus.csr_rdata, 32'h0000_0002); end
    rd_setup(12'h341);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_2000) begin n_err++; $display("FAIL exc_wins_mepc got=%h exp=%h", bus.csr_rdata, 32'h0000_2000); end
    idle();
  endtask

  task automatic test_back_to_back();
    cmd(2'b01, 12'h341, 32'h0000_0200); tick();
    idle(); bus.is_mret = 1'b1; bus.pc = 32'h0000_3000; tick();
    idle();
    n_cmp++; if (bus.epc !== 32'h0000_0200) begin n_err++; $display("FAIL mret_epc got=%h exp=%h", bus.epc, 32'h0000_0200); end
    n_cmp++; if (bus.epc_taken !== 1'b1) begin n_err++; $display("FAIL mret_taken got=%b exp=1", bus.epc_taken); end
    rd_setup(12'h300);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0088) begin n_err++; $display("FAIL mret_mstatus got=%h exp=%h", bus.csr_rdata, 32'h0000_0088); end
    idle(); tick();
    n_cmp++; if (bus.epc_taken !== 1'b1) begin n_err++; $display("FAIL retrap_taken got=%b exp=1", bus.epc_taken); end
    n_cmp++; if (bus.epc !== 32'h1000_0040) begin n_err++; $display("FAIL retrap_epc got=%h exp=%h", bus.epc, 32'h1000_0040); end
    rd_setup(12'h341);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_3000) begin n_err++; $display("FAIL retrap_mepc got=%h exp=%h", bus.csr_rdata, 32'h0000_3000); end
    idle();
  endtask

  task automatic test_squash_illegal();
    bus.irq = 4'b0000; idle(); tick(); tick(); tick();
    cmd(2'b10, 12'h300, 32'h0000_0008); tick();
    cmd(2'b11, 12'h300, 32'h0000_0008); bus.exc_valid = 1'b1; bus.exc_cause = 5'd3; tick();
    cmd(2'b01, 12'h304, 32'h0000_0000); bus.exc_valid = 1'b1; bus.exc_cause = 5'd4; tick();
    idle();
    rd_setup(12'h304);
    n_cmp++; if (bus.csr_rdata !== 32'h0007_0000) begin n_err++; $display("FAIL squash_mie got=%h exp=%h", bus.csr_rdata, 32'h0007_0000); end
    rd_setup(12'h342);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0004) begin n_err++; $display("FAIL squash_mcause got=%h exp=%h", bus.csr_rdata, 32'h0000_0004); end
    rd_setup(12'h300);
    n_cmp++; if (bus.csr_rdata !== 32'h0000_0000) begin n_err++; $display("FAIL squash_mstatus got=%h exp=%h", bus.csr_rdata, 32'h0000_0000); end
    rd_setup(12'h7C0);
    n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL illegal_flag got=%b exp=1", bus.csr_illegal); end
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL illegal_rdata got=%h exp=%h", bus.csr_rdata, 32'h0); end
    bus.csr_op = 2'b00; #1;
    n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_noop got=%b exp=0", bus.csr_illegal); end
    idle();
  endtask

  task automatic test_mcycle_wrap();
    cmd(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    cmd(2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    idle(); tick();
    rd_setup(12'hB00);
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL wrap_lo got=%h exp=%h", bus.csr_rdata, 32'h0); end
    rd_setup(12'hB80);
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL wrap_hi got=%h exp=%h", bus.csr_rdata, 32'h0); end
    idle(); tick();
    rd_setup(12'hB00);
    n_cmp++; if (bus.csr_rdata !== 32'h1) begin n_err++; $display("FAIL wrap_next got=%h exp=%h", bus.csr_rdata, 32'h1); end
    idle();
  endtask

  task automatic test_random();
    logic [11:0] tab [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h301};
    logic [32:0] rd;
    logic [31:0] exp_rd;
    logic        exp_il;
    for (int c = 0; c < 600; c++) begin
      idle();
      bus.csr_op = 2'($urandom_range(0, 3));
      bus.csr_addr = tab[$urandom_range(0, 9)];
      bus.csr_wdata = $urandom;
      bus.pc = $urandom;
      if ($urandom_range(0, 7) == 0) bus.irq = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin bus.exc_valid = 1'b1; bus.exc_cause = 5'($urandom); end
      if ($urandom_range(0, 11) == 0) bus.is_mret = 1'b1;
      #1;
      rd = m_read(bus.csr_addr);
      exp_rd = (bus.csr_op != 0 && rd[32]) ? rd[31:0] : 32'h0;
      exp_il = (bus.csr_op != 0) && !rd[32];
      n_cmp++; if (bus.csr_rdata !== exp_rd) begin n_err++; $display("FAIL rand_rdata c=%0d addr=%h got=%h exp=%h", c, bus.csr_addr, bus.csr_rdata, exp_rd); end
      n_cmp++; if (bus.csr_illegal !== exp_il) begin n_err++; $display("FAIL rand_illegal c=%0d got=%b exp=%b", c, bus.csr_illegal, exp_il); end
      tick();
      n_cmp++; if (bus.epc_taken !== m_taken) begin n_err++; $display("FAIL rand_taken c=%0d got=%b exp=%b", c, bus.epc_taken, m_taken); end
      n_cmp++; if (bus.epc !== m_epc) begin n_err++; $display("FAIL rand_epc c=%0d got=%h exp=%h", c, bus.epc, m_epc); end
    end
    idle();
  endtask

  task automatic test_reset_redirect();
    idle(); bus.exc_valid = 1'b1; bus.exc_cause = 5'd3; bus.pc = 32'h0000_5000; tick();
    idle();
    n_cmp++; if (bus.epc_taken !== 1'b1) begin n_err++; $display("FAIL rstredir_pre got=%b exp=1", bus.epc_taken); end
    #10;
    rst = 1'b0; m_reset();
    #1;
    n_cmp++; if (bus.epc_taken !== 1'b0) begin n_err++; $display("FAIL rstredir_taken got=%b exp=0", bus.epc_taken); end
    n_cmp++; if (bus.epc !== 32'h0) begin n_err++; $display("FAIL rstredir_epc got=%h exp=%h", bus.epc, 32'h0); end
    rd_setup(12'h342);
    n_cmp++; if (bus.csr_rdata !== 32'h0) begin n_err++; $display("FAIL rstredir_mcause got=%h exp=%h", bus.csr_rdata, 32'h0); end
    idle(); bus.irq = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (bus.epc_taken !== 1'b0) begin n_err++; $display("FAIL rstredir_after%0d got=%b exp=0", k, bus.epc_taken); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_vectored_irq();
    test_priority();
    test_back_to_back();
    test_squash_illegal();
    test_mcycle_wrap();
    test_random();
    test_reset_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
